link_param_loader: RTL and testbench
====================================

# link_param_loader

Loads per-link weight and boundary-condition parameters for an array of `neighbor_link_internal` instances before decoding begins. It accepts a valid/ready stream of one parameter word per link and stores the words in a register bank. It then drives the bank as flat `weight_in` / `boundary_condition_in` buses and holds them stable while the top-level controller runs `STAGE_PARAMETERS_LOADING`. It sits between the host/config interface and the link array, beside the global stage controller.

## Interface
Parameters:
- `NUM_LINKS`, 16, number of links served; bank depth.
- `MAX_WEIGHT`, 2, maximum legal link weight; must match the links.
- `LINK_BIT_WIDTH`, `$clog2(MAX_WEIGHT+1)`, derived width of the weight field.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `global_stage`  in  `STAGE_WIDTH`  current decoder stage from the stage controller.
- `start`  in  1  begin a new load; honoured only in IDLE.
- `in_valid`  in  1  parameter word valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  `LINK_BIT_WIDTH+2`  `{boundary_condition[1:0], weight}` for the next link, in index order.
- `weight_bus`  out  `NUM_LINKS*LINK_BIT_WIDTH`  link i's weight at slice i.
- `boundary_bus`  out  `NUM_LINKS*2`  link i's boundary condition at slice i.
- `params_ready`  out  1  bank complete; waiting for the parameter stage.
- `busy`  out  1  high in LOAD, READY or COMMIT.
- `done`  out  1  one-cycle pulse when the parameter stage ends.
- `error`  out  2  sticky flags: bit0 = a weight was clamped, bit1 = protocol violation.

## Operation
- FSM states: IDLE, LOAD, READY, COMMIT.
- IDLE:
  - `in_ready`=0.
  - On `start`: clear the index counter and `error`, then go to LOAD.
- LOAD:
  - `in_ready`=1.
  - Each `in_valid & in_ready` writes `bank[idx]` and increments `idx`.
  - Accepting the word at `idx==NUM_LINKS-1` moves the FSM to READY.
- READY:
  - `params_ready`=1.
  - When `global_stage==STAGE_PARAMETERS_LOADING`, go to COMMIT.
- COMMIT:
  - Stay while `global_stage==STAGE_PARAMETERS_LOADING`.
  - On the first cycle it differs, go to IDLE and pulse `done`.
- Weight clamp: an incoming weight greater than `MAX_WEIGHT` is stored as `MAX_WEIGHT` and sets `error[0]`.
- Boundary condition: stored unmodified. Value 3 is legal and means non-existent.
- Bank persistence: bank contents persist across loads. Only LOAD writes the bank, so the buses are stable in READY, COMMIT and IDLE.
- Protocol violation: `global_stage==STAGE_PARAMETERS_LOADING` while in IDLE or LOAD sets `error[1]`. This is not a state change; the links would latch a partial or stale bank.
- `start` outside IDLE is ignored.
- Index counter width is `$clog2(NUM_LINKS)`, minimum 1. It never wraps; LOAD exits on the last index.

## Timing
- Reset values: state IDLE, bank all zero (weight 0, bc 0), `idx` 0, `in_ready` 0, `params_ready` 0, `busy` 0, `done` 0, `error` 0.
- Assert/deassert: reset is applied asynchronously and released synchronously to `clk` by the top level.
- Output decode: `in_ready`, `params_ready` and `busy` are decoded from registered state only; no combinational path from `in_valid`.
- Write latency: a word accepted at edge t appears on the buses after edge t.
- Stage-ready latency: the last word accepted at edge t gives `params_ready`=1 from t+1.
- Empty stream: `in_valid` low in LOAD simply stalls; there is no timeout.
- Stage in the cycle after entering READY: COMMIT is entered on the next edge.
- `done` timing: asserted for exactly one cycle, the cycle after the stage leaves PARAMETERS_LOADING.
- Reset mid-LOAD or mid-COMMIT: everything returns to reset values immediately; a partial bank is discarded (zeroed).

## Structure
- From the shared `parameters.sv`: `STAGE_WIDTH` and `STAGE_PARAMETERS_LOADING`.
- Add to the shared package: the FSM state encoding localparams (`LPL_IDLE`, `LPL_LOAD`, `LPL_READY`, `LPL_COMMIT`).
- Single module; no sub-module needed. The bank is a flat register array with an index-decoded write enable.

## Test plan
- **Basic load:** NUM_LINKS=4, MAX_WEIGHT=2. `start`, stream words (bc,w) = (0,1),(1,2),(2,0),(0,2) with `in_valid` always high -> `weight_bus`={2,0,2,1}, `boundary_bus`={0,2,1,0}, `params_ready` high on cycle 5, `error`=0.
- **Backpressure gaps:** toggle `in_valid` 1,0,1,0,... -> only valid cycles write; ordering is preserved; READY is entered after the fourth accepted word.
- **Commit sequence:** in READY, drive `global_stage`=PARAMETERS_LOADING for 3 cycles, then MEASUREMENT_LOADING -> FSM in COMMIT for 3 cycles, `done` pulses once, buses unchanged, state IDLE.
- **Clamp:** send weight 3 with MAX_WEIGHT=2 -> stored as 2 and `error[0]`=1; `error[0]` is cleared on the next `start`.
- **Protocol error:** drive PARAMETERS_LOADING while in LOAD after 2 words -> `error[1]`=1, FSM stays in LOAD, `idx`=2.
- **Reset mid-load:** assert `reset` after 2 accepted words -> bank zero, state IDLE, `in_ready` 0, all within the reset cycle without waiting for a clock edge.

Source files
------------

// File: rtl/link_param_loader_pkg.sv
// Shared decoder definitions used by the link parameter loader: stage codes,
// loader FSM encoding and a small width helper.
package link_param_loader_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROWING             = 3'd3;

  typedef enum logic [1:0] {
    LPL_IDLE   = 2'd0,
    LPL_LOAD   = 2'd1,
    LPL_READY  = 2'd2,
    LPL_COMMIT = 2'd3
  } lpl_state_t;

  // Index counters need at least one bit even for a single-entry bank.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/link_param_loader_if.sv
// Valid/ready stream carrying one {boundary_condition, weight} word per link.
interface link_param_loader_if #(
  parameter int DATA_WIDTH = 4
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/link_param_loader.sv
// Streams per-link weight/boundary words into a register bank and holds the bank
// on flat buses while the stage controller runs the parameter-loading stage.
module link_param_loader
  import link_param_loader_pkg::*;
#(
  parameter int NUM_LINKS      = 16,
  parameter int MAX_WEIGHT     = 2,
  parameter int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [STAGE_WIDTH-1:0]             global_stage,
  input  logic                               start,
  link_param_loader_if.slave                 stream,
  output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_bus,
  output logic [NUM_LINKS*2-1:0]             boundary_bus,
  output logic                               params_ready,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         error
);

  localparam int                       IDX_WIDTH = idx_width(NUM_LINKS);
  localparam logic [IDX_WIDTH-1:0]      LAST_IDX  = IDX_WIDTH'(NUM_LINKS - 1);
  localparam logic [LINK_BIT_WIDTH-1:0] MAX_W     = LINK_BIT_WIDTH'(MAX_WEIGHT);

  lpl_state_t                state;
  lpl_state_t                state_next;
  logic [IDX_WIDTH-1:0]      idx;
  logic [LINK_BIT_WIDTH-1:0] bank_weight   [NUM_LINKS];
  logic [1:0]                bank_boundary [NUM_LINKS];

  logic                      accept;
  logic                      stage_params;
  logic                      over_max;
  logic [LINK_BIT_WIDTH-1:0] word_weight;
  logic [LINK_BIT_WIDTH-1:0] stored_weight;
  logic [1:0]                word_boundary;

  assign stage_params  = (global_stage == STAGE_PARAMETERS_LOADING);
  assign accept        = (state == LPL_LOAD) && stream.in_valid;
  assign word_weight   = stream.in_data[LINK_BIT_WIDTH-1:0];
  assign word_boundary = stream.in_data[LINK_BIT_WIDTH+1:LINK_BIT_WIDTH];
  assign over_max      = (word_weight > MAX_W);
  assign stored_weight = over_max ? MAX_W : word_weight;

  // Handshake and status come from the state register only, never from in_valid.
  assign stream.in_ready = (state == LPL_LOAD);
  assign params_ready    = (state == LPL_READY);
  assign busy            = (state != LPL_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LPL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LPL_IDLE:   if (start) state_next = LPL_LOAD;
      LPL_LOAD:   if (accept && (idx == LAST_IDX)) state_next = LPL_READY;
      LPL_READY:  if (stage_params) state_next = LPL_COMMIT;
      LPL_COMMIT: if (!stage_params) state_next = LPL_IDLE;
      default:    state_next = LPL_IDLE;
    endcase
  end

  // A stage request while the bank is partial or stale is flagged, not acted on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      error <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == LPL_COMMIT) && !stage_params;
      if ((state == LPL_IDLE) && start) begin
        idx   <= '0;
        error <= {stage_params, 1'b0};
      end else begin
        if (accept) begin
          if (idx != LAST_IDX) idx <= idx + 1'b1;
          if (over_max) error[0] <= 1'b1;
        end
        if (stage_params && ((state == LPL_IDLE) || (state == LPL_LOAD))) error[1] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        bank_weight[i]   <= '0;
        bank_boundary[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (accept && (idx == IDX_WIDTH'(i))) begin
          bank_weight[i]   <= stored_weight;
          bank_boundary[i] <= word_boundary;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LINKS; g++) begin : g_bus
    assign weight_bus[g*LINK_BIT_WIDTH +: LINK_BIT_WIDTH] = bank_weight[g];
    assign boundary_bus[g*2 +: 2]                         = bank_boundary[g];
  end

endmodule

// File: tb/tb_link_param_loader.sv
// Directed bench for link_param_loader with a 4-link, max-weight-2 configuration:
// table-driven load vectors plus hand-written commit, clamp, protocol and reset sequences.
module tb_link_param_loader;
  import link_param_loader_pkg::*;

  localparam int NL = 4;
  localparam int MW = 2;
  localparam int LW = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [STAGE_WIDTH-1:0] global_stage = STAGE_IDLE;
  logic                   start = 1'b0;
  logic [NL*LW-1:0]       weight_bus;
  logic [NL*2-1:0]        boundary_bus;
  logic                   params_ready;
  logic                   busy;
  logic                   done;
  logic [1:0]             error;

  int errors = 0;
  int checks = 0;

  link_param_loader_if #(.DATA_WIDTH(LW + 2)) stream_if ();

  link_param_loader #(.NUM_LINKS(NL), .MAX_WEIGHT(MW), .LINK_BIT_WIDTH(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .global_stage (global_stage),
    .start        (start),
    .stream       (stream_if),
    .weight_bus   (weight_bus),
    .boundary_bus (boundary_bus),
    .params_ready (params_ready),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_start;
    logic       valid;
    logic [1:0] bc;
    logic [1:0] w;
    logic       exp_in_ready;
    logic       exp_params_ready;
    logic [7:0] exp_wbus;
    logic [7:0] exp_bbus;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start              = v.do_start;
    stream_if.in_valid = v.valid;
    stream_if.in_data  = {v.bc, v.w};
    checkOutput("in_ready_pre", 16'(stream_if.in_ready), 16'(v.exp_in_ready));
    tick();
    start              = 1'b0;
    stream_if.in_valid = 1'b0;
    checkOutput("params_ready", 16'(params_ready), 16'(v.exp_params_ready));
    checkOutput("weight_bus", 16'(weight_bus), 16'(v.exp_wbus));
    checkOutput("boundary_bus", 16'(boundary_bus), 16'(v.exp_bbus));
    checkOutput("error", 16'(error), 16'(v.exp_err));
  endtask

  task automatic runVectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(vecs[i]);
  endtask

  task automatic sendWord(input logic [1:0] bc, input logic [1:0] w);
    stream_if.in_valid = 1'b1;
    stream_if.in_data  = {bc, w};
    tick();
    stream_if.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Basic load from reset: start, then four back-to-back words.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 8'h01, 8'h00, 2'b00};
    vecs[2]  = '{1'b0, 1'b1, 2'd1, 2'd2, 1'b1, 1'b0, 8'h09, 8'h04, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 8'h09, 8'h24, 2'b00};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b1, 1'b1, 8'h89, 8'h24, 2'b00};
    // Second load with in_valid toggling; idle cycles carry garbage that must not land.
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h89, 8'h24, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 8'h88, 8'h27, 2'b00};
    vecs[7]  = '{1'b0, 1'b0, 2'd0, 2'd3, 1'b1, 1'b0, 8'h88, 8'h27, 2'b00};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 1'b0, 8'h84, 8'h23, 2'b00};
    vecs[9]  = '{1'b0, 1'b0, 2'd1, 2'd3, 1'b1, 1'b0, 8'h84, 8'h23, 2'b00};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 8'h94, 8'h13, 2'b00};
    vecs[11] = '{1'b0, 1'b0, 2'd2, 2'd3, 1'b1, 1'b0, 8'h94, 8'h13, 2'b00};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 8'h94, 8'h93, 2'b00};
    // Start is ignored once the bank is complete.
    vecs[13] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 8'h94, 8'h93, 2'b00};
    vecs[14] = '{1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 8'h94, 8'h93, 2'b00};

    stream_if.in_valid = 1'b0;
    stream_if.in_data  = '0;

    #12;
    checkOutput("reset_in_ready", 16'(stream_if.in_ready), 16'd0);
    checkOutput("reset_busy", 16'(busy), 16'd0);
    checkOutput("reset_params_ready", 16'(params_ready), 16'd0);
    checkOutput("reset_done", 16'(done), 16'd0);
    checkOutput("reset_error", 16'(error), 16'd0);
    checkOutput("reset_weight_bus", 16'(weight_bus), 16'd0);
    checkOutput("reset_boundary_bus", 16'(boundary_bus), 16'd0);
    tick();
    reset = 1'b0;

    runVectors(0, 4);

    // Commit: three cycles of the parameter stage, then leave it.
    global_stage = STAGE_PARAMETERS_LOADING;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("commit_busy", 16'(busy), 16'd1);
      checkOutput("commit_params_ready", 16'(params_ready), 16'd0);
      checkOutput("commit_done", 16'(done), 16'd0);
      checkOutput("commit_in_ready", 16'(stream_if.in_ready), 16'd0);
    end
    global_stage = STAGE_MEASUREMENT_LOADING;
    tick();
    checkOutput("done_pulse", 16'(done), 16'd1);
    checkOutput("idle_busy", 16'(busy), 16'd0);
    checkOutput("commit_weight_bus", 16'(weight_bus), 16'h89);
    checkOutput("commit_boundary_bus", 16'(boundary_bus), 16'h24);
    checkOutput("commit_error", 16'(error), 16'd0);
    tick();
    checkOutput("done_cleared", 16'(done), 16'd0);

    runVectors(5, 14);

    // Short commit to get back to IDLE.
    global_stage = STAGE_PARAMETERS_LOADING;
    tick();
    global_stage = STAGE_MEASUREMENT_LOADING;
    tick();
    checkOutput("done_pulse2", 16'(done), 16'd1);

    // Clamp on the first word, then a stage request mid-load after two words.
    start = 1'b1;
    tick();
    start = 1'b0;
    sendWord(2'd1, 2'd3);
    checkOutput("clamp_weight_bus", 16'(weight_bus), 16'h96);
    checkOutput("clamp_boundary_bus", 16'(boundary_bus), 16'h91);
    checkOutput("clamp_error", 16'(error), 16'b01);
    sendWord(2'd0, 2'd0);
    checkOutput("load2_weight_bus", 16'(weight_bus), 16'h92);
    global_stage = STAGE_PARAMETERS_LOADING;
    tick();
    global_stage = STAGE_MEASUREMENT_LOADING;
    checkOutput("proto_error", 16'(error), 16'b11);
    checkOutput("proto_in_ready", 16'(stream_if.in_ready), 16'd1);
    checkOutput("proto_params_ready", 16'(params_ready), 16'd0);
    sendWord(2'd2, 2'd1);
    checkOutput("proto_third_params_ready", 16'(params_ready), 16'd0);
    sendWord(2'd3, 2'd2);
    checkOutput("proto_fourth_params_ready", 16'(params_ready), 16'd1);
    checkOutput("proto_weight_bus", 16'(weight_bus), 16'h92);
    checkOutput("proto_boundary_bus", 16'(boundary_bus), 16'hE1);
    checkOutput("proto_error_sticky", 16'(error), 16'b11);

    global_stage = STAGE_PARAMETERS_LOADING;
    tick();
    global_stage = STAGE_MEASUREMENT_LOADING;
    tick();
    checkOutput("done_pulse3", 16'(done), 16'd1);

    // Error flags clear on the next start.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_clears_error", 16'(error), 16'd0);
    sendWord(2'd0, 2'd1);
    sendWord(2'd0, 2'd1);
    checkOutput("partial_weight_bus", 16'(weight_bus), 16'h95);
    checkOutput("partial_boundary_bus", 16'(boundary_bus), 16'hE0);

    // Asynchronous reset mid-load, observed before the next clock edge.
    reset = 1'b1;
    #2;
    checkOutput("async_in_ready", 16'(stream_if.in_ready), 16'd0);
    checkOutput("async_busy", 16'(busy), 16'd0);
    checkOutput("async_weight_bus", 16'(weight_bus), 16'd0);
    checkOutput("async_boundary_bus", 16'(boundary_bus), 16'd0);
    checkOutput("async_error", 16'(error), 16'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("post_reset_in_ready", 16'(stream_if.in_ready), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
